// File: rtl/udp_conn_key_extractor.sv
`default_nettype none
// ============================================================================
// Module   : udp_conn_key_extractor
// Brief    : Zero-latency Ethernet/IPv4/UDP header parser on a 64-bit
//            AXI-Stream. Frame beats pass through combinationally; each
//            qualifying UDP frame yields one {src_ip, src_port, dst_port}
//            lookup key on a valid/ready port.
// Options  : STATS_EN - adds key / non-UDP / runt wrap-around counters.
// Revision : 1.0 - initial release
// ============================================================================
module udp_conn_key_extractor #(
    parameter logic [15:0] ETHERTYPE_IPV4 = 16'h0800,
    parameter logic [7:0]  IP_VER_IHL     = 8'h45,
    parameter logic [7:0]  UDP_PROTO      = 8'h11
`ifdef STATS_EN
    ,
    parameter int          CNT_W          = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_axis_frame_tvalid,
    input  logic             s_axis_frame_tlast,
    input  logic [63:0]      s_axis_frame_tdata,
    input  logic [7:0]       s_axis_frame_tstrb,
    output logic             s_axis_frame_tready,
    output logic             m_axis_frame_tvalid,
    output logic             m_axis_frame_tlast,
    output logic [63:0]      m_axis_frame_tdata,
    output logic [7:0]       m_axis_frame_tstrb,
    input  logic             m_axis_frame_tready,
    output logic             m_axis_key_valid,
    output logic [63:0]      m_axis_key_data,
    input  logic             m_axis_key_ready
`ifdef STATS_EN
    ,
    output logic [CNT_W-1:0] stat_key_cnt,
    output logic [CNT_W-1:0] stat_nonudp_cnt,
    output logic [CNT_W-1:0] stat_runt_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_HDR  = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  beat_cnt_q, beat_cnt_d;
    logic        qualify_q, qualify_d;
    logic [31:0] src_ip_q, src_ip_d;
    logic        key_valid_q, key_valid_d;
    logic [63:0] key_data_q, key_data_d;

    logic        w_in_hdr;
    logic        w_hdr4;
    logic        w_stall;
    logic        w_accept;
    logic        w_key_set;
    logic [15:0] w_ethertype;
    logic [7:0]  w_ver_ihl;
    logic [7:0]  w_proto;
    logic [31:0] w_src_ip;
    logic [15:0] w_src_port;
    logic [15:0] w_dst_port;

    // Header fields are in network byte order, byte 0 in the low lane.
    assign w_ethertype = {s_axis_frame_tdata[39:32], s_axis_frame_tdata[47:40]};
    assign w_ver_ihl   = s_axis_frame_tdata[55:48];
    assign w_proto     = s_axis_frame_tdata[63:56];
    assign w_src_ip    = {s_axis_frame_tdata[23:16], s_axis_frame_tdata[31:24],
                          s_axis_frame_tdata[39:32], s_axis_frame_tdata[47:40]};
    assign w_src_port  = {s_axis_frame_tdata[23:16], s_axis_frame_tdata[31:24]};
    assign w_dst_port  = {s_axis_frame_tdata[39:32], s_axis_frame_tdata[47:40]};

    // Beat 4 is held off while an earlier key is still waiting to leave, so
    // a key is never overwritten before the connection manager takes it.
    assign w_in_hdr  = (state_q == ST_HDR);
    assign w_hdr4    = w_in_hdr && (beat_cnt_q == 3'd4);
    assign w_stall   = w_hdr4 && key_valid_q && !m_axis_key_ready;
    assign w_accept  = s_axis_frame_tvalid && s_axis_frame_tready;
    assign w_key_set = w_accept && w_hdr4 && qualify_q;

    assign s_axis_frame_tready = m_axis_frame_tready && !w_stall;
    assign m_axis_frame_tvalid = s_axis_frame_tvalid && !w_stall;
    assign m_axis_frame_tlast  = s_axis_frame_tlast;
    assign m_axis_frame_tdata  = s_axis_frame_tdata;
    assign m_axis_frame_tstrb  = s_axis_frame_tstrb;

    assign m_axis_key_valid = key_valid_q;
    assign m_axis_key_data  = key_data_q;

    // Parser next state: header beat counting, field checks and src_ip capture.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        qualify_d  = qualify_q;
        src_ip_d   = src_ip_q;
        if (w_accept) begin
            if (w_in_hdr) begin
                case (beat_cnt_q)
                    3'd0:    qualify_d = 1'b0;
                    3'd1:    qualify_d = (w_ethertype == ETHERTYPE_IPV4) &&
                                         (w_ver_ihl == IP_VER_IHL);
                    3'd2:    qualify_d = qualify_q && (w_proto == UDP_PROTO);
                    3'd3:    src_ip_d  = w_src_ip;
                    default: ;
                endcase
                if (s_axis_frame_tlast) begin
                    beat_cnt_d = 3'd0;
                end else if (beat_cnt_q == 3'd4) begin
                    state_d    = ST_BODY;
                    beat_cnt_d = 3'd0;
                end else begin
                    beat_cnt_d = beat_cnt_q + 3'd1;
                end
            end else if (s_axis_frame_tlast) begin
                state_d    = ST_HDR;
                beat_cnt_d = 3'd0;
            end
        end
    end

    // Key register: a new key takes priority over the handshake clear.
    always_comb begin
        key_valid_d = key_valid_q;
        key_data_d  = key_data_q;
        if (key_valid_q && m_axis_key_ready) begin
            key_valid_d = 1'b0;
        end
        if (w_key_set) begin
            key_valid_d = 1'b1;
            key_data_d  = {src_ip_q, w_src_port, w_dst_port};
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HDR;
            beat_cnt_q  <= 3'd0;
            qualify_q   <= 1'b0;
            src_ip_q    <= 32'd0;
            key_valid_q <= 1'b0;
            key_data_q  <= 64'd0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            qualify_q   <= qualify_d;
            src_ip_q    <= src_ip_d;
            key_valid_q <= key_valid_d;
            key_data_q  <= key_data_d;
        end
    end

`ifdef STATS_EN
    logic             w_nonudp;
    logic             w_runt;
    logic [CNT_W-1:0] key_cnt_q, key_cnt_d;
    logic [CNT_W-1:0] nonudp_cnt_q, nonudp_cnt_d;
    logic [CNT_W-1:0] runt_cnt_q, runt_cnt_d;

    assign w_nonudp = w_accept && w_hdr4 && !qualify_q;
    assign w_runt   = w_accept && w_in_hdr && s_axis_frame_tlast &&
                      (beat_cnt_q < 3'd4);

    assign stat_key_cnt    = key_cnt_q;
    assign stat_nonudp_cnt = nonudp_cnt_q;
    assign stat_runt_cnt   = runt_cnt_q;

    // Statistics increments; counters wrap naturally.
    always_comb begin
        key_cnt_d    = key_cnt_q;
        nonudp_cnt_d = nonudp_cnt_q;
        runt_cnt_d   = runt_cnt_q;
        if (w_key_set) key_cnt_d    = key_cnt_q + 1'b1;
        if (w_nonudp)  nonudp_cnt_d = nonudp_cnt_q + 1'b1;
        if (w_runt)    runt_cnt_d   = runt_cnt_q + 1'b1;
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_cnt_q    <= '0;
            nonudp_cnt_q <= '0;
            runt_cnt_q   <= '0;
        end else begin
            key_cnt_q    <= key_cnt_d;
            nonudp_cnt_q <= nonudp_cnt_d;
            runt_cnt_q   <= runt_cnt_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_udp_conn_key_extractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_udp_conn_key_extractor
// Brief    : Self-checking bench for udp_conn_key_extractor: table of frame
//            vectors, hand-written stall/reset sequences and random frames
//            checked against a byte-offset frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udp_conn_key_extractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_tvalid, s_tlast, s_tready;
    logic [63:0] s_tdata;
    logic [7:0]  s_tstrb;
    logic        m_tvalid, m_tlast, m_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tstrb;
    logic        key_valid, key_ready;
    logic [63:0] key_data;
`ifdef STATS_EN
    logic [31:0] stat_key_cnt, stat_nonudp_cnt, stat_runt_cnt;
`endif

    always #5 clk = ~clk;

    udp_conn_key_extractor dut (
        .clk                 (clk),
        .rst                 (rst),
        .s_axis_frame_tvalid (s_tvalid),
        .s_axis_frame_tlast  (s_tlast),
        .s_axis_frame_tdata  (s_tdata),
        .s_axis_frame_tstrb  (s_tstrb),
        .s_axis_frame_tready (s_tready),
        .m_axis_frame_tvalid (m_tvalid),
        .m_axis_frame_tlast  (m_tlast),
        .m_axis_frame_tdata  (m_tdata),
        .m_axis_frame_tstrb  (m_tstrb),
        .m_axis_frame_tready (m_tready),
        .m_axis_key_valid    (key_valid),
        .m_axis_key_data     (key_data),
        .m_axis_key_ready    (key_ready)
`ifdef STATS_EN
        ,
        .stat_key_cnt        (stat_key_cnt),
        .stat_nonudp_cnt     (stat_nonudp_cnt),
        .stat_runt_cnt       (stat_runt_cnt)
`endif
    );

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } beat_t;

    typedef struct {
        logic [15:0] et;
        logic [7:0]  vihl;
        logic [7:0]  proto;
        logic [31:0] ip;
        logic [15:0] sp;
        logic [15:0] dp;
        int          nb;
        bit          rand_m;
        int          exp_nkeys;
        logic [63:0] exp_key;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    beat_t       tx_q[$];
    beat_t       rx_q[$];
    beat_t       exp_q[$];
    logic [63:0] key_rx[$];
    logic [63:0] key_exp[$];
    logic [7:0]  fbytes [0:255];
    int          fbeats;
    logic        drv_acc = 1'b0;
    bit          abort = 1'b0;
    bit          m_rand = 1'b0;
    bit          k_rand = 1'b0;
    logic        key_pend = 1'b0;
    logic [63:0] key_hold = 64'd0;
    beat_t       mon_b;
    vec_t        vt [9];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Frame as a flat byte array; header fields at their Ethernet/IP/UDP offsets.
    task automatic build_frame(input logic [15:0] et, input logic [7:0] vihl,
                               input logic [7:0] proto, input logic [31:0] ip,
                               input logic [15:0] sp, input logic [15:0] dp,
                               input int nb);
        for (int k = 0; k < 256; k++) fbytes[k] = 8'($urandom);
        fbytes[12] = et[15:8];  fbytes[13] = et[7:0];
        fbytes[14] = vihl;
        fbytes[23] = proto;
        fbytes[26] = ip[31:24]; fbytes[27] = ip[23:16];
        fbytes[28] = ip[15:8];  fbytes[29] = ip[7:0];
        fbytes[34] = sp[15:8];  fbytes[35] = sp[7:0];
        fbytes[36] = dp[15:8];  fbytes[37] = dp[7:0];
        fbeats = nb;
    endtask

    task automatic model_key(output bit v, output logic [63:0] k);
        v = (fbeats >= 5) && ({fbytes[12], fbytes[13]} == 16'h0800) &&
            (fbytes[14] == 8'h45) && (fbytes[23] == 8'h11);
        k = {fbytes[26], fbytes[27], fbytes[28], fbytes[29],
             fbytes[34], fbytes[35], fbytes[36], fbytes[37]};
    endtask

    task automatic enqueue_frame();
        beat_t b;
        for (int bi = 0; bi < fbeats; bi++) begin
            for (int n = 0; n < 8; n++) b.data[8*n +: 8] = fbytes[8*bi + n];
            b.strb = 8'($urandom);
            b.last = (bi == fbeats - 1);
            tx_q.push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_idle(input int extra);
        int n = 0;
        while ((tx_q.size() > 0 || s_tvalid) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= 5000) begin
            errors++;
            $display("FAIL idle_timeout: got %0d beats pending expected 0", tx_q.size());
        end
        repeat (extra) @(posedge clk);
    endtask

    task automatic compare_beats(input string nm);
        chk({nm, " beat_count"}, 128'(rx_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("%s beat%0d", nm, i), 128'(rx_q[i]), 128'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic compare_keys(input string nm);
        chk({nm, " key_count"}, 128'(key_rx.size()), 128'(key_exp.size()));
        for (int i = 0; i < key_exp.size() && i < key_rx.size(); i++)
            chk($sformatf("%s key%0d", nm, i), 128'(key_rx[i]), 128'(key_exp[i]));
        key_rx.delete();
        key_exp.delete();
    endtask

    // Frame driver: holds each beat until the DUT accepts it.
    initial begin
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 64'd0; s_tstrb = 8'd0;
        forever begin
            @(posedge clk); #1;
            if (drv_acc && tx_q.size() > 0) tx_q.delete(0);
            if (abort) tx_q.delete();
            if (tx_q.size() > 0) begin
                s_tvalid = 1'b1;
                s_tdata  = tx_q[0].data;
                s_tstrb  = tx_q[0].strb;
                s_tlast  = tx_q[0].last;
            end else begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
            end
        end
    end

    // Optional random back-pressure on both downstream readies.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (m_rand) m_tready  = 1'($urandom_range(0, 1));
            if (k_rand) key_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitors, sampled mid-cycle while inputs are stable.
    always @(negedge clk) begin
        drv_acc <= s_tvalid && s_tready;
        if (!rst) begin
            if (m_tvalid && m_tready) begin
                mon_b.data = m_tdata;
                mon_b.strb = m_tstrb;
                mon_b.last = m_tlast;
                rx_q.push_back(mon_b);
            end
            if (key_pend) begin
                checks++;
                if (!key_valid || key_data !== key_hold) begin
                    errors++;
                    $display("FAIL key_stable: got valid=%b data=%h expected valid=1 data=%h",
                             key_valid, key_data, key_hold);
                end
            end
            if (key_valid && key_ready) key_rx.push_back(key_data);
            key_pend <= key_valid && !key_ready;
            key_hold <= key_data;
        end else begin
            key_pend <= 1'b0;
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit          v;
        logic [63:0] k, ka, kb;
        int          n;

        vt[0] = '{16'h0800, 8'h45, 8'h11, 32'h0A000001, 16'h1234, 16'h5678, 8,  0, 1, 64'h0A000001_1234_5678};
        vt[1] = '{16'h86DD, 8'h45, 8'h11, 32'h0A000001, 16'h1234, 16'h5678, 8,  0, 0, 64'd0};
        vt[2] = '{16'h0800, 8'h45, 8'h06, 32'h0A000001, 16'h1234, 16'h5678, 8,  0, 0, 64'd0};
        vt[3] = '{16'h0800, 8'h46, 8'h11, 32'h0A000001, 16'h1234, 16'h5678, 8,  0, 0, 64'd0};
        vt[4] = '{16'h0800, 8'h45, 8'h11, 32'h0A000001, 16'h1234, 16'h5678, 3,  0, 0, 64'd0};
        vt[5] = '{16'h0800, 8'h45, 8'h11, 32'hC0A80164, 16'h0035, 16'hD431, 8,  0, 1, 64'hC0A80164_0035_D431};
        vt[6] = '{16'h0800, 8'h45, 8'h11, 32'h01020304, 16'hFFFF, 16'h0001, 5,  0, 1, 64'h01020304_FFFF_0001};
        vt[7] = '{16'h0800, 8'h45, 8'h11, 32'h01020304, 16'hFFFF, 16'h0001, 4,  0, 0, 64'd0};
        vt[8] = '{16'h0800, 8'h45, 8'h11, 32'hAC100005, 16'hABCD, 16'h0050, 20, 1, 1, 64'hAC100005_ABCD_0050};

        // Reset state and passthrough of ready.
        rst = 1'b1; m_tready = 1'b1; key_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst key_valid", 128'(key_valid), 128'd0);
        chk("rst key_data", 128'(key_data), 128'd0);
        chk("rst m_tvalid", 128'(m_tvalid), 128'd0);
        chk("rst s_tready_hi", 128'(s_tready), 128'd1);
        m_tready = 1'b0;
        #1;
        chk("rst s_tready_lo", 128'(s_tready), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0; m_tready = 1'b1; key_ready = 1'b1;
        @(negedge clk);
        chk("post_rst key_valid", 128'(key_valid), 128'd0);

        // Table-driven frames.
        for (int i = 0; i < 9; i++) begin
            m_rand = vt[i].rand_m;
            if (!m_rand) m_tready = 1'b1;
            key_ready = 1'b1;
            build_frame(vt[i].et, vt[i].vihl, vt[i].proto, vt[i].ip, vt[i].sp, vt[i].dp, vt[i].nb);
            enqueue_frame();
            wait_idle(4);
            m_rand = 1'b0;
            m_tready = 1'b1;
            compare_beats($sformatf("vec%0d", i));
            if (vt[i].exp_nkeys == 1) key_exp.push_back(vt[i].exp_key);
            compare_keys($sformatf("vec%0d", i));
        end

        // Back-to-back keys with the connection manager stalled.
        key_ready = 1'b0;
        ka = 64'h0A000001_1234_5678;
        kb = 64'hC0A80164_0035_D431;
        build_frame(16'h0800, 8'h45, 8'h11, 32'h0A000001, 16'h1234, 16'h5678, 8);
        enqueue_frame();
        build_frame(16'h0800, 8'h45, 8'h11, 32'hC0A80164, 16'h0035, 16'hD431, 8);
        enqueue_frame();
        n = 0;
        do begin @(negedge clk); n++; end while (s_tready && n < 100);
        chk("stall reached", 128'(n < 100), 128'd1);
        for (int c = 0; c < 3; c++) begin
            chk("stall s_tready", 128'(s_tready), 128'd0);
            chk("stall m_tvalid", 128'(m_tvalid), 128'd0);
            chk("stall key_valid", 128'(key_valid), 128'd1);
            chk("stall key_data", 128'(key_data), 128'(ka));
            @(negedge clk);
        end
        @(posedge clk); #1;
        key_ready = 1'b1;
        @(posedge clk); #1;
        key_ready = 1'b0;
        @(negedge clk);
        chk("stall key2_valid", 128'(key_valid), 128'd1);
        chk("stall key2_data", 128'(key_data), 128'(kb));
        key_ready = 1'b1;
        wait_idle(4);
        compare_beats("stall");
        key_exp.push_back(ka);
        key_exp.push_back(kb);
        compare_keys("stall");

        // Reset in the middle of a UDP frame, then a fresh frame.
        build_frame(16'h0800, 8'h45, 8'h11, 32'h0B0B0B0B, 16'h1111, 16'h2222, 8);
        enqueue_frame();
        n = 0;
        do begin @(negedge clk); n++; end while (rx_q.size() < 2 && n < 100);
        chk("mid_rst beats_seen", 128'(n < 100), 128'd1);
        @(posedge clk); #1;
        rst = 1'b1; abort = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid_rst key_valid", 128'(key_valid), 128'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0; abort = 1'b0;
        rx_q.delete(); exp_q.delete(); key_rx.delete();
        build_frame(16'h0800, 8'h45, 8'h11, 32'h0A0A0001, 16'h4000, 16'h0FA0, 8);
        enqueue_frame();
        wait_idle(4);
        compare_beats("after_rst");
        key_exp.push_back(64'h0A0A0001_4000_0FA0);
        compare_keys("after_rst");

        // Random frames under random back-pressure.
        m_rand = 1'b1; k_rand = 1'b1;
        for (int f = 0; f < 40; f++) begin
            logic [15:0] et;
            logic [7:0]  vh, pr;
            case ($urandom_range(0, 2)) 0: et = 16'h86DD; default: et = 16'h0800; endcase
            case ($urandom_range(0, 2)) 0: vh = 8'h46;    default: vh = 8'h45;    endcase
            case ($urandom_range(0, 2)) 0: pr = 8'h06;    default: pr = 8'h11;    endcase
            build_frame(et, vh, pr, $urandom, 16'($urandom), 16'($urandom), int'($urandom_range(1, 12)));
            model_key(v, k);
            if (v) key_exp.push_back(k);
            enqueue_frame();
        end
        wait_idle(2);
        m_rand = 1'b0; k_rand = 1'b0;
        @(posedge clk); #1;
        m_tready = 1'b1; key_ready = 1'b1;
        repeat (4) @(posedge clk);
        compare_beats("random");
        compare_keys("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
